if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of `ID_Stage`. It holds the program counter and a word-addressed instruction memory. It registers the fetched instruction and PC+4 into the IF/ID pipeline register, whose outputs drive `ID_Stage.in_instruction` and `ID_Stage.in_new_pc_value`. It supports stall, branch redirect with wrong-path squash, and a synchronous write port for program loading.

---
 rtl/if_stage.sv | 69 ++++++
 tb/tb_if_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with PC, instruction memory and IF/ID register
module if_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_stall,
    input  logic        in_PCSrc,
    input  logic [31:0] in_branch_target,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic [31:0] new_pc_value_out,
    output logic        valid_out
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0]   imem [IMEM_DEPTH];
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    // Byte addresses are reduced to word indices; upper bits alias so the
    // memory wraps modulo its depth.
    assign rd_idx   = pc[AW+1:2];
    assign wr_idx   = imem_waddr[AW+1:2];
    assign pc_plus4 = pc + 32'd4;

    // Bits that are deliberately ignored: alignment bits and aliased upper bits.
    logic unused_bits;
    assign unused_bits = ^{imem_waddr[31:AW+2], imem_waddr[1:0], in_branch_target[1:0]};

    // Program-load write port; runs regardless of reset so code can be loaded
    // while the pipeline is held. Nonblocking write gives read-before-write
    // against a fetch of the same word on the same edge.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[wr_idx] <= imem_wdata;
        end
    end

    // PC and IF/ID register: redirect beats stall, stall beats sequential fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            instruction_out  <= 32'd0;
            new_pc_value_out <= 32'd0;
            valid_out        <= 1'b0;
        end else if (in_PCSrc) begin
            pc               <= {in_branch_target[31:2], 2'b00};
            instruction_out  <= 32'd0;
            new_pc_value_out <= 32'd0;
            valid_out        <= 1'b0;
        end else if (!in_stall) begin
            pc               <= pc_plus4;
            instruction_out  <= imem[rd_idx];
            new_pc_value_out <= pc_plus4;
            valid_out        <= 1'b1;
        end
    end

    assign pc_out = pc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard testbench for if_stage against a behavioural fetch model
module tb_if_stage;

    localparam int DS = 4;
    localparam int DB = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_stall;
    logic        in_PCSrc;
    logic [31:0] in_branch_target;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    logic [31:0] pc_s, instr_s, npc_s;
    logic        valid_s;
    logic [31:0] pc_b, instr_b, npc_b;
    logic        valid_b;

    if_stage #(.IMEM_DEPTH(DS), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .in_stall(in_stall), .in_PCSrc(in_PCSrc),
        .in_branch_target(in_branch_target), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc_out(pc_s), .instruction_out(instr_s),
        .new_pc_value_out(npc_s), .valid_out(valid_s)
    );

    if_stage #(.IMEM_DEPTH(DB), .RESET_PC(32'd0)) dut_big (
        .clk(clk), .rst_n(rst_n), .in_stall(in_stall), .in_PCSrc(in_PCSrc),
        .in_branch_target(in_branch_target), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc_out(pc_b), .instruction_out(instr_b),
        .new_pc_value_out(npc_b), .valid_out(valid_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr_s;
        logic [31:0] instr_b;
        logic [31:0] npc;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    event async_ev;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_pop   = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_npc, m_instr_s, m_instr_b;
    logic        m_valid;
    logic [31:0] mem_s [DS];
    logic [31:0] mem_b [DB];

    function automatic int widx(input logic [31:0] a, input int depth);
        return int'((a >> 2) % depth);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.pc = m_pc; e.instr_s = m_instr_s; e.instr_b = m_instr_b;
        e.npc = m_npc; e.valid = m_valid;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_npc = 32'd0; m_instr_s = 32'd0; m_instr_b = 32'd0; m_valid = 1'b0;
    endtask

    // One clock edge of stimulus: drive at the falling edge, predict the
    // outputs after the next rising edge and queue that prediction.
    task automatic cycle(input logic rst, input logic stall, input logic pcsrc,
                         input logic [31:0] tgt, input logic we,
                         input logic [31:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst_n = rst; in_stall = stall; in_PCSrc = pcsrc; in_branch_target = tgt;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        if (!rst) begin
            model_reset();
        end else if (pcsrc) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_npc = 32'd0; m_instr_s = 32'd0; m_instr_b = 32'd0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr_s = mem_s[widx(m_pc, DS)];
            m_instr_b = mem_b[widx(m_pc, DB)];
            m_npc     = m_pc + 32'd4;
            m_valid   = 1'b1;
            m_pc      = m_pc + 32'd4;
        end
        if (we) begin
            mem_s[widx(wa, DS)] = wd;
            mem_b[widx(wa, DB)] = wd;
        end
        push_exp();
    endtask

    task automatic fetch(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'd0, 0, 32'd0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after every rising edge (or an asynchronous reset event) pop
    // the next prediction and compare both instances.
    always begin
        exp_t e;
        @(posedge clk or async_ev);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_pop++;
            chk("pc_s",    pc_s,          e.pc);
            chk("instr_s", instr_s,       e.instr_s);
            chk("npc_s",   npc_s,         e.npc);
            chk("valid_s", 32'(valid_s),  32'(e.valid));
            chk("pc_b",    pc_b,          e.pc);
            chk("instr_b", instr_b,       e.instr_b);
            chk("npc_b",   npc_b,         e.npc);
            chk("valid_b", 32'(valid_b),  32'(e.valid));
        end
    end

    task automatic async_pulse();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_exp();
        -> async_ev;
        #2;
        rst_n = 1'b1;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h00210800; prog[1] = 32'h00421000;
        prog[2] = 32'h00631800; prog[3] = 32'h8C010004;
        rst_n = 1'b0; in_stall = 0; in_PCSrc = 0; in_branch_target = 0;
        imem_we = 0; imem_waddr = 0; imem_wdata = 0;
        model_reset();
        #1;
        push_exp();
        -> async_ev;

        // Load program while held in reset; low words last so the small
        // instance keeps the program words after aliasing.
        for (int a = DB - 1; a >= 4; a--) cycle(0, 0, 0, 32'd0, 1, 32'(a * 4), $urandom);
        for (int a = 0; a < 4; a++) cycle(0, 0, 0, 32'd0, 1, 32'(a * 4), prog[a]);

        // Sequential fetch of words 0..3.
        fetch(4);
        // Back to holding word 1: redirect to 0, fetch 2, stall 2, resume.
        cycle(1, 0, 1, 32'd0, 0, 0, 0);
        fetch(2);
        cycle(1, 1, 0, 32'd0, 0, 0, 0);
        cycle(1, 1, 0, 32'd0, 0, 0, 0);
        fetch(1);
        // Redirect to unaligned 9 -> pc 8, then word 2.
        cycle(1, 0, 1, 32'h0000_0009, 0, 0, 0);
        fetch(1);
        // Stall and redirect together: redirect wins.
        cycle(1, 1, 1, 32'd0, 0, 0, 0);
        fetch(5);
        // Asynchronous reset mid-stream, then restart from word 0.
        async_pulse();
        fetch(3);
        // PC wraps at the top of the address space.
        cycle(1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        fetch(2);
        // Same-address write during fetch: old word captured, new one later.
        cycle(1, 0, 1, 32'h0000_0020, 0, 0, 0);
        cycle(1, 0, 0, 32'd0, 1, 32'h0000_0021, 32'hDEADBEEF);
        fetch(2);
        cycle(1, 0, 1, 32'h0000_0020, 0, 0, 0);
        fetch(1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, st, br, we;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) >= 2);
            st  = ($urandom_range(0, 99) < 25);
            br  = ($urandom_range(0, 99) < 15);
            we  = ($urandom_range(0, 99) < 30);
            tgt = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h3FF);
            cycle(r, st, br, tgt, we, $urandom & 32'h3FF, $urandom);
            if ($urandom_range(0, 99) == 0) async_pulse();
        end

        cycle(1, 0, 0, 32'd0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0 || n_pop != n_push) begin
            n_fail++;
            $display("FAIL scoreboard_drain: popped %0d expected %0d", n_pop, n_push);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
